// File: rtl/execute_stage_p_if.sv
// rtl/execute_stage_p_if.sv - decode-side and memory-side handshake bundle for the Y86-64 execute stage
interface execute_stage_p_if #(
    parameter int W = 64
) ();
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] valE;
    logic         cnd;
    logic [2:0]   cc;
    logic         err;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, valE, cnd, cc, err
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, valE, cnd, cc, err
    );
endinterface

// File: rtl/execute_stage_p.sv
// rtl/execute_stage_p.sv - Y86-64 execute stage: ALU, condition codes, Cnd; EXEC_MUL_EN adds iterative mulq
module execute_stage_p #(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input logic              clk,
    input logic              rst_n,
    execute_stage_p_if.slave bus
);
    localparam int CW = $clog2(W);

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE} state_t;
`endif

    state_t       state;
    logic         out_valid_q, cnd_q, err_q;
    logic [W-1:0] val_e_q;
    logic [2:0]   cc_q;

    logic [W-1:0] alu_a, alu_b, res;
    logic [1:0]   fn;
    logic         of_res, is_op, is_mul, illegal, cond_raw, cond_hit, accept;
    logic         zf, sf, of;

`ifdef EXEC_MUL_EN
    logic [W-1:0]  acc, mcand, mplier;
    logic [CW-1:0] cnt;
`endif

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.valE      = val_e_q;
    assign bus.cnd       = cnd_q;
    assign bus.cc        = cc_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_op  = (bus.icode == 4'h6);
`ifdef EXEC_MUL_EN
    assign is_mul = is_op && (bus.ifun == 4'h4);
`else
    assign is_mul = 1'b0;
`endif
    assign illegal = is_op && (bus.ifun > 4'h3) && !is_mul;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        fn    = 2'd0;
        case (bus.icode)
            4'h2:       alu_a = bus.valA;
            4'h3:       alu_a = bus.valC;
            4'h4, 4'h5: begin alu_a = bus.valC; alu_b = bus.valB; end
            4'h6:       begin alu_a = bus.valA; alu_b = bus.valB; fn = bus.ifun[1:0]; end
            4'h8, 4'hA: begin alu_a = '0 - W'(STACK_STEP); alu_b = bus.valB; end
            4'h9, 4'hB: begin alu_a = W'(STACK_STEP); alu_b = bus.valB; end
            default:    ;
        endcase
    end

    always_comb begin
        res    = '0;
        of_res = 1'b0;
        case (fn)
            2'd0: begin
                res    = alu_b + alu_a;
                of_res = (alu_a[W-1] == alu_b[W-1]) && (res[W-1] != alu_a[W-1]);
            end
            2'd1: begin
                res    = alu_b - alu_a;
                of_res = (alu_a[W-1] != alu_b[W-1]) && (res[W-1] != alu_b[W-1]);
            end
            2'd2:    res = alu_b & alu_a;
            default: res = alu_b ^ alu_a;
        endcase
    end

    // Conditions read the flags as they stand before this edge.
    always_comb begin
        cond_raw = 1'b0;
        case (bus.ifun)
            4'h0:    cond_raw = 1'b1;
            4'h1:    cond_raw = (sf ^ of) | zf;
            4'h2:    cond_raw = sf ^ of;
            4'h3:    cond_raw = zf;
            4'h4:    cond_raw = !zf;
            4'h5:    cond_raw = !(sf ^ of);
            4'h6:    cond_raw = !(sf ^ of) && !zf;
            default: cond_raw = 1'b0;
        endcase
        cond_hit = ((bus.icode == 4'h2) || (bus.icode == 4'h7)) && cond_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= 3'b100;
`ifdef EXEC_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef EXEC_MUL_EN
                        if (is_mul) begin
                            state       <= MUL;
                            out_valid_q <= 1'b0;
                            acc         <= '0;
                            mcand       <= bus.valB;
                            mplier      <= bus.valA;
                            cnt         <= '0;
                        end else
`endif
                        begin
                            out_valid_q <= 1'b1;
                            val_e_q     <= illegal ? '0 : res;
                            cnd_q       <= cond_hit;
                            err_q       <= illegal;
                            if (is_op && !illegal)
                                cc_q <= {(res == '0), res[W-1], of_res};
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1))
                        state <= DONE;
                end
                DONE: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b1;
                    val_e_q     <= acc;
                    cnd_q       <= 1'b0;
                    err_q       <= 1'b0;
                    cc_q        <= {(acc == '0), acc[W-1], 1'b0};
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
